// File: rtl/tiny_nn_stream_arb.sv
// Packet-granular arbiter for the tiny NN accelerator's 16-bit command/data input; returns
// convolve result bytes to their owner. Define TINY_NN_ARB_FIXED_PRIO_EN for fixed priority.
module tiny_nn_stream_arb #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned CountWidth    = 12,
    parameter int unsigned ParamWords    = 8,
    parameter logic [15:0] IdleWord      = 16'hFFFF,
    parameter logic [3:0]  CmdOpConvolve = 4'h1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [NumReq*16-1:0]      req_data_i,
    output logic [NumReq-1:0]         req_ready_o,
    output logic [15:0]               nn_data_o,
    input  logic [7:0]                nn_data_i,
    output logic                      res_valid_o,
    output logic [$clog2(NumReq)-1:0] res_id_o,
    output logic [7:0]                res_data_o,
    output logic                      busy_o,
    output logic [NumReq-1:0]         underrun_o,
    input  logic                      clear_err_i
);

    localparam int unsigned    IdW       = $clog2(NumReq);
    localparam int unsigned    PcW       = (ParamWords > 1) ? $clog2(ParamWords) : 1;
    localparam int unsigned    EcW       = CountWidth + 1;
    localparam logic [PcW-1:0] ParamLast = PcW'(ParamWords - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StParam = 2'd1;
    localparam logic [1:0] StExec  = 2'd2;

    function automatic logic is_convolve(input logic [15:0] hdr);
        return (hdr[15:12] == CmdOpConvolve);
    endfunction

    function automatic logic [15:0] req_word(input logic [NumReq*16-1:0] data,
                                             input logic [IdW-1:0]       id);
        return data[{id, 4'b0000} +: 16];
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            next_state_s;
    logic [IdW-1:0]        grant_r;
    logic [CountWidth-1:0] count_r;
    logic [PcW-1:0]        param_cnt_r;
    logic [EcW-1:0]        exec_cnt_r;
    logic [15:0]           nn_data_r;
    logic                  out_exec_r;
    logic [IdW-1:0]        out_id_r;
    logic                  res_valid_r;
    logic [IdW-1:0]        res_id_r;
    logic [7:0]            res_data_r;
    logic                  busy_r;
    logic [NumReq-1:0]     underrun_r;

    logic [NumReq-1:0]     ready_s;
    logic [15:0]           word_s;
    logic                  exec_word_s;
    logic [NumReq-1:0]     und_set_s;
    logic                  win_found_s;
    logic [IdW-1:0]        win_id_s;
    logic [15:0]           hdr_s;
    logic [15:0]           grant_word_s;

    assign hdr_s        = req_word(req_data_i, win_id_s);
    assign grant_word_s = req_word(req_data_i, grant_r);

`ifdef TINY_NN_ARB_FIXED_PRIO_EN
    // Fixed-priority winner search: lowest index wins.
    always_comb begin
        logic [IdW-1:0] cand;
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand        = '0;
        for (int unsigned k = 32'd0; k < NumReq; k++) begin
            cand = IdW'(k);
            if (req_valid_i[cand] && !win_found_s) begin
                win_found_s = 1'b1;
                win_id_s    = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end
`else
    logic [IdW-1:0] last_r;

    // Round-robin winner search starting just after the last granted requester.
    always_comb begin
        logic [IdW-1:0] cand;
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand        = '0;
        for (int unsigned k = 32'd1; k <= NumReq; k++) begin
            cand = IdW'((32'(last_r) + k) % NumReq);
            if (req_valid_i[cand] && !win_found_s) begin
                win_found_s = 1'b1;
                win_id_s    = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer advances on every Idle grant, single-word packets included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_r <= IdW'(NumReq - 1);
        end else if ((state_r == StIdle) && win_found_s) begin
            last_r <= win_id_s;
        end
    end
`endif

    // Next state, handshake and the word presented to the core this cycle.
    always_comb begin
        next_state_s = state_r;
        ready_s      = '0;
        word_s       = IdleWord;
        exec_word_s  = 1'b0;
        und_set_s    = '0;
        case (state_r)
            StIdle: begin
                if (win_found_s) begin
                    ready_s[win_id_s] = 1'b1;
                    word_s            = hdr_s;
                    if (is_convolve(hdr_s)) begin
                        next_state_s = StParam;
                    end else begin
                        next_state_s = StIdle;
                    end
                end else begin
                    word_s = IdleWord;
                end
            end
            StParam, StExec: begin
                // The core cannot stall: a missing word becomes fp zero but still uses its slot.
                ready_s[grant_r] = 1'b1;
                if (req_valid_i[grant_r]) begin
                    word_s = grant_word_s;
                end else begin
                    word_s             = 16'h0000;
                    und_set_s[grant_r] = 1'b1;
                end
                if (state_r == StParam) begin
                    if (param_cnt_r == ParamLast) begin
                        next_state_s = StExec;
                    end else begin
                        next_state_s = StParam;
                    end
                end else begin
                    exec_word_s = 1'b1;
                    if (exec_cnt_r == '0) begin
                        next_state_s = StIdle;
                    end else begin
                        next_state_s = StExec;
                    end
                end
            end
            default: begin
                next_state_s = StIdle;
            end
        endcase
    end

    // Packet bookkeeping: owner, length and the per-phase word counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_r     <= '0;
            count_r     <= '0;
            param_cnt_r <= '0;
            exec_cnt_r  <= '0;
        end else begin
            case (state_r)
                StIdle: begin
                    if (win_found_s && is_convolve(hdr_s)) begin
                        grant_r     <= win_id_s;
                        count_r     <= hdr_s[CountWidth-1:0];
                        param_cnt_r <= '0;
                    end
                end
                StParam: begin
                    param_cnt_r <= param_cnt_r + PcW'(1);
                    if (param_cnt_r == ParamLast) begin
                        // 2*(count+1)-1 without an adder: append a one below count.
                        exec_cnt_r <= {count_r, 1'b1};
                    end
                end
                StExec: begin
                    if (exec_cnt_r != '0) begin
                        exec_cnt_r <= exec_cnt_r - EcW'(1);
                    end
                end
                default: begin
                    param_cnt_r <= '0;
                end
            endcase
        end
    end

    // State and registered core-facing word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= StIdle;
            busy_r     <= 1'b0;
            nn_data_r  <= IdleWord;
            out_exec_r <= 1'b0;
            out_id_r   <= '0;
        end else begin
            state_r    <= next_state_s;
            busy_r     <= (next_state_s != StIdle);
            nn_data_r  <= word_s;
            out_exec_r <= exec_word_s;
            out_id_r   <= grant_r;
        end
    end

    // Capture the core's byte one cycle after each Exec word is on its input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_data_r  <= 8'h00;
        end else begin
            res_valid_r <= out_exec_r;
            if (out_exec_r) begin
                res_id_r   <= out_id_r;
                res_data_r <= nn_data_i;
            end
        end
    end

    // Sticky gap flags; a new gap beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_r <= '0;
        end else begin
            underrun_r <= (underrun_r & ~{NumReq{clear_err_i}}) | und_set_s;
        end
    end

    assign req_ready_o = ready_s & {NumReq{rst_ni}};
    assign nn_data_o   = nn_data_r;
    assign res_valid_o = res_valid_r;
    assign res_id_o    = res_id_r;
    assign res_data_o  = res_data_r;
    assign busy_o      = busy_r;
    assign underrun_o  = underrun_r;

endmodule
